// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_arith_pkg
//  Description : Shared definitions for the bit-serial arithmetic units
//                (subtractor now, adder variant later): sequencer state
//                encoding and the default operand width.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_arith_pkg;

    // Default operand / result width in bits.
    localparam int c_DEFAULT_WIDTH = 8;

    // Sequencer states shared by all serial arithmetic units.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : Combinational one-bit subtractor cell, d = a - b - bin.
//                Ports:
//                  i_a    - minuend bit
//                  i_b    - subtrahend bit
//                  i_bin  - borrow in
//                  o_d    - difference bit
//                  o_bout - borrow out
//  Revision    : 1.0  initial release
// ============================================================================
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    logic w_ab_xor;

    assign w_ab_xor = i_a ^ i_b;
    assign o_d      = w_ab_xor ^ i_bin;
    // A borrow leaves this bit when b exceeds a outright, or when a and b
    // are equal and a borrow is already pending from the bit below.
    assign o_bout   = (~i_a & i_b) | (~w_ab_xor & i_bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial subtractor computing {bo, d} = a - b - bi over
//                WIDTH clock cycles, LSB first, with a start/done handshake.
//                WIDTH must be at least 2.
//                Ports:
//                  clk      - rising-edge clock
//                  rst_n    - synchronous active-low reset
//                  i_start  - request, sampled only while idle
//                  i_a      - minuend, sampled with i_start
//                  i_b      - subtrahend, sampled with i_start
//                  i_bi     - borrow in, sampled with i_start
//                  o_busy   - high while bits are being processed
//                  o_done   - one-cycle pulse when o_d / o_bo become valid
//                  o_d      - difference, held until the next completion
//                  o_bo     - borrow out (sign of the WIDTH+1-bit result)
//  Revision    : 1.0  initial release
// ============================================================================
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bi,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_d,
    output logic             o_bo
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_br;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_d;
    logic               r_bo;

    logic               w_diff;
    logic               w_bout;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_unused_res_lsb;

    // ------------------------------------------------------------------
    // One-bit arithmetic cell working on the current operand LSBs.
    // ------------------------------------------------------------------
    full_subtractor u_cell (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_br),
        .o_d    (w_diff),
        .o_bout (w_bout)
    );

    assign w_last     = (r_cnt == c_LAST);
    // Each new difference bit enters at the MSB; after WIDTH shifts the
    // first (LSB) bit has arrived at position 0.
    assign w_res_next = {w_diff, r_res[WIDTH-1:1]};
    // The old LSB falls off the end of the result shift register.
    assign w_unused_res_lsb = r_res[0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand shifters, borrow flop, counter, result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
            r_d   <= '0;
            r_bo  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a   <= i_a;
                        r_b   <= i_b;
                        r_br  <= i_bi;
                        r_cnt <= '0;
                        r_res <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_bout;
                    r_res <= w_res_next;
                    if (w_last) begin
                        // Publish on the edge that enters DONE; the
                        // counter stays put rather than wrapping.
                        r_d  <= w_res_next;
                        r_bo <= w_bout;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy = (r_state == ST_SHIFT);
    assign o_done = (r_state == ST_DONE);
    assign o_d    = r_d;
    assign o_bo   = r_bo;

endmodule : serial_subtractor
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing D = A − B − Bin over WIDTH cycles, one bit per clock, LSB first. It is the inverse-operation companion to the combinational eight-bit ripple adder. It trades area for latency and gives the datapath a start/done-handshaked arithmetic unit with the adder's bit-vector conventions. Result and borrow-out together form a WIDTH+1-bit two's-complement-style result {bo, d}, mirroring the adder's {co, so}.

## Interface
- WIDTH, default 8: operand and result width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled with start.
- b  input  WIDTH  subtrahend; sampled with start.
- bi  input  1  borrow-in; sampled with start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when d/bo become valid.
- d  output  WIDTH  difference; held stable until next accepted start.
- bo  output  1  borrow-out; 1 when a < b + bi (unsigned).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start=1, then:
  - latch a, b into shift registers;
  - load the borrow flop with bi;
  - clear the bit counter;
  - clear the result register;
  - go to SHIFT.
- SHIFT, each cycle:
  - compute on the LSB of the shift registers, with br = borrow flop:
    - diff = a0 ^ b0 ^ br
    - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
  - shift the a and b registers right by one;
  - shift diff into the result MSB, shifting the result right;
  - increment the counter.
  - After the counter reaches WIDTH−1, go to DONE.
- DONE, for one cycle:
  - done=1;
  - d = result register;
  - bo = final borrow;
  - then go to IDLE.
- start in SHIFT or DONE is ignored, not queued. The operand inputs may change freely after acceptance.
- d and bo update only on entry to DONE and hold their value through IDLE until the next completion.
- Arithmetic is modulo 2^WIDTH. {bo, d} equals (a − b − bi) mod 2^(WIDTH+1), with bo acting as the sign.
- Counter width: $clog2(WIDTH); no wrap beyond WIDTH−1.

## Timing
- start is sampled high in IDLE at edge k.
- busy is high during cycles k+1 … k+WIDTH.
- done is high for exactly one cycle, k+WIDTH+1, with d/bo valid from that same edge.
- Total latency is WIDTH+1 cycles: 9 for WIDTH=8.
- Back-to-back: the earliest next accepted start is the cycle after done (IDLE). Maximum throughput is one result per WIDTH+2 cycles.
- Reset value of every output: busy=0, done=0, d=0, bo=0. State returns to IDLE; the counter, shift registers and borrow flop clear.
- Reset asserted mid-SHIFT or during DONE:
  - the operation aborts at the next edge;
  - no done pulse;
  - d/bo clear to 0.
- Simultaneous rst_n=0 and start=1: reset wins; nothing is accepted.

## Structure
- Shared package serial_arith_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - default WIDTH constant 8.
  - The serial adder variant will reuse this package.
- One natural sub-module: full_subtractor, a combinational 1-bit cell (a, b, bin → d, bout). It is instantiated once and is also testable stand-alone.
- The top level holds the FSM, counter, operand shift registers, result register and borrow flop.

## Test plan
- a=3, b=2, bi=0, start pulse → busy for 8 cycles; done at start+9 with d=1, bo=0.
- a=0, b=1, bi=0 → d=255, bo=1 ({bo,d}=9'h1FF, i.e. −1).
- a=255, b=255, bi=1 → d=255, bo=1. Then a=128, b=127, bi=0 → d=1, bo=0.
- Start held high continuously with a=10, b=4:
  - exactly one operation per 10 cycles;
  - start pulses during busy/done are ignored;
  - operands changed mid-SHIFT do not affect d=6.
- rst_n low for one cycle at start+4 → busy=0, done never pulses, d=0, bo=0. A subsequent start with a=5, b=5 completes with d=0, bo=0.
- Exhaustive sweep of all a, b ∈ 0..255 and bi ∈ {0,1} → {bo,d} matches a − b − bi mod 512 for every case; done occurs exactly once per start.
